ram_sp_arbiter: RTL and testbench

Shares one single-port block RAM IP between two requesters, A and B, using round-robin arbitration. After reset it clears the RAM to zero, then issues at most one read or write per cycle. Read data returns to the owning requester after the RAM's fixed read latency. It sits between the RAM IP instance and the client logic in top.

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/rd_tag_pipe.sv | 31 +++
 rtl/ram_sp_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_sp_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states, owner tags and
// the read-tracking tag carried alongside each read in flight.
package ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam int RAM_ADDR_W_DEF = 10;

    function automatic int ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks reads through the RAM
// latency so returned data can be steered to the requester that issued it.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ram_sp_arbiter.sv
// Two-requester round-robin front end for one single-port RAM; clears the RAM
// after reset. Define ARB_FIXED_PRIO_EN to make A always win a tie instead.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W   = RAM_ADDR_W_DEF,
    parameter int                DATA_W   = 16,
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ram_depth(ADDR_W) - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    owner_e            rr_last_q, rr_last_d;
    logic              init_done_q, init_done_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_wins_tie;
    rd_tag_t           tag_in, tag_out;

    // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt;
    // the transfer happens at the clock edge where req && gnt are both high.
    // Grants open only once init_done is up, so no client command overlaps init.
`ifdef ARB_FIXED_PRIO_EN
    assign a_wins_tie = 1'b1;
`else
    assign a_wins_tie = (rr_last_q == OWN_B);
`endif

    assign a_gnt = init_done_q && a_req && (!b_req ||  a_wins_tie);
    assign b_gnt = init_done_q && b_req && (!a_req || !a_wins_tie);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        init_done_d = init_done_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        case (state_q)
            ST_INIT: begin
                ram_en_d   = 1'b1;
                ram_we_d   = 1'b1;
                ram_addr_d = cnt_q;
                ram_din_d  = INIT_VAL;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (a_gnt) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = a_we;
                    ram_addr_d = a_addr;
                    ram_din_d  = a_wdata;
                    rr_last_d  = OWN_A;
                end else if (b_gnt) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = b_we;
                    ram_addr_d = b_addr;
                    ram_din_d  = b_wdata;
                    rr_last_d  = OWN_B;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (a_gnt && !a_we) || (b_gnt && !b_we);
        tag_in.owner = b_gnt ? OWN_B : OWN_A;
    end

    // One extra stage beyond RD_LAT: the tag leaves the pipe in the cycle
    // ram_dout is valid, and the return registers below capture both.
    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rr_last_q   <= OWN_B;
            init_done_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            init_done_q <= init_done_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            a_rvalid_q  <= tag_out.valid && (tag_out.owner == OWN_A);
            b_rvalid_q  <= tag_out.valid && (tag_out.owner == OWN_B);
            if (tag_out.valid && (tag_out.owner == OWN_A)) begin
                a_rdata_q <= ram_dout;
            end
            if (tag_out.valid && (tag_out.owner == OWN_B)) begin
                b_rdata_q <= ram_dout;
            end
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign a_rvalid  = a_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rvalid  = b_rvalid_q;
    assign b_rdata   = b_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter with a small RAM model; expected RAM commands and
// read returns are queued with their due cycle and checked by a monitor.
module tb_ram_sp_arbiter;

  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;

  logic          clk;
  logic          sys_rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en, ram_we, init_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // {due cycle, we, addr, din} and {due cycle, owner, data}
  logic [36:0] cmd_q[$];
  logic [32:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sp_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_LAT   (RD_LAT),
    .INIT_VAL (16'h0000)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  // ---------------- RAM model with RD_LAT read latency ----------------
  logic [DW-1:0] mem   [1 << AW];
  logic [DW-1:0] rpipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      rpipe[0] <= mem[ram_addr];
    end
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign ram_dout = rpipe[RD_LAT-1];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ram_en) begin
      if (cmd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL ram_cmd_unexpected: got addr %0h we %0b at cycle %0d expected none", ram_addr, ram_we, cyc);
      end else begin
        check("ram_cmd", {16'(cyc), ram_we, ram_addr, ram_din}, 64'(cmd_q.pop_front()));
      end
    end
    if (a_rvalid && b_rvalid) begin
      n_cmp++;
      n_err++;
      $display("FAIL rvalid_both: got a=1 b=1 at cycle %0d expected at most one", cyc);
    end else if (a_rvalid || b_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rvalid_unexpected: got a=%0b b=%0b at cycle %0d expected none", a_rvalid, b_rvalid, cyc);
      end else begin
        check("rd_return", {16'(cyc), b_rvalid, (b_rvalid ? b_rdata : a_rdata)}, 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic eag, input logic ebg, input logic [DW-1:0] erd);
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    check("a_gnt", a_gnt, eag);
    check("b_gnt", b_gnt, ebg);
    if (eag) begin
      cmd_q.push_back({16'(cyc + 1), aw, aa, ad});
      if (!aw) exp_q.push_back({16'(cyc + RD_LAT + 2), 1'b0, erd});
    end
    if (ebg) begin
      cmd_q.push_back({16'(cyc + 1), bw, ba, bd});
      if (!bw) exp_q.push_back({16'(cyc + RD_LAT + 2), 1'b1, erd});
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Releases reset with the current requests held and checks the clear sweep.
  task automatic run_init();
    int r;
    @(negedge clk);
    sys_rst = 1'b0;
    r = cyc;
    for (int k = 0; k < (1 << AW); k++) cmd_q.push_back({16'(r + 1 + k), 1'b1, 4'(k), 16'h0000});
    for (int k = 0; k <= (1 << AW); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("init_a_gnt", a_gnt, 0);
      check("init_b_gnt", b_gnt, 0);
      check("init_done_low", init_done, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 1; a_wdata = 16'hAAAA;
    b_req = 1; b_we = 1; b_addr = 2; b_wdata = 16'hBBBB;
    #1;
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_init_done", init_done, 0);
    check("rst_a_gnt", a_gnt, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);

    run_init();
    // A wins the first tie after reset
    step(1, 1, 1, 16'hAAAA, 1, 1, 2, 16'hBBBB, 1, 0, 0);
    check("init_done_high", init_done, 1);
    step(0, 0, 0, 0,        1, 1, 2, 16'hBBBB, 0, 1, 0);
    // single client: write then read-after-write of addr 5
    step(1, 1, 5, 16'h1234, 0, 0, 0, 0,        1, 0, 0);
    step(1, 0, 5, 0,        0, 0, 0, 0,        1, 0, 16'h1234);
    step(0, 0, 0, 0,        1, 1, 7, 16'h5A5A, 0, 1, 0);

    // contention: both hold reads of addr 1 and addr 2
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      step(1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 16'hAAAA);
`else
      if (i % 2 == 0) step(1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 16'hAAAA);
      else            step(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 16'hBBBB);
`endif
    end
    step(0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 16'hBBBB);
    // boundary addresses hold the cleared value
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000);
`ifdef ARB_FIXED_PRIO_EN
    step(1, 0, 15, 0, 1, 0, 7, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 0,  1, 0, 7, 0, 0, 1, 16'h5A5A);
`else
    step(1, 0, 15, 0, 1, 0, 7, 0, 0, 1, 16'h5A5A);
    step(1, 0, 15, 0, 0, 0, 0, 0, 1, 0, 16'h0000);
`endif
    repeat (RD_LAT + 3) idle();

    // reset one cycle after a read grant: that read must never return
    step(1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 16'h1234);
    void'(exp_q.pop_back());
    @(negedge clk);
    a_req = 0; b_req = 0;
    #2;
    sys_rst = 1'b1;
    #1;
    check("rst2_ram_en", ram_en, 0);
    check("rst2_init_done", init_done, 0);
    a_req = 1; a_we = 0; a_addr = 5;
    b_req = 1; b_we = 0; b_addr = 1;
    run_init();
    // re-init cleared the RAM, and A again wins the first tie
    step(1, 0, 5, 0, 1, 0, 1, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 16'h0000);
    repeat (RD_LAT + 4) idle();

    check("cmd_q_drained", cmd_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
